fn8_eval_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered 8-input boolean evaluator among NUM_REQ requesters. The evaluator computes y = ((a&b)|c) ^ ((d&e)|f) ^ (g&h) and is instantiated inside this block. The block accepts one operand vector at a time, sequences it through the evaluator's one-cycle registered stage, and returns the 1-bit result to the granted requester over a valid/ready response channel. It sits between requester agents and the shared evaluator. It is the only path by which requesters reach the evaluator.

---
 rtl/fn8_eval_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fn8_eval_arbiter.sv
// Round-robin arbiter sharing one registered 8-input boolean evaluator among NUM_REQ requesters.
// Latency: accept in IDLE, evaluate in EVAL, respond from RESP (2 cycles to rsp_valid, 3-cycle minimum spacing).
// Backpressure: rsp_valid/rsp_result held in RESP until the granted rsp_ready; no request accepted meanwhile.
module fn8_eval_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_operand,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic                 rsp_result,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     eval_count
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t          state_q;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] grant_q;
    logic [7:0]      op_q;
    logic            eval_q;
    logic [CNT_W-1:0] cnt_q;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [7:0]      pick_op;
    logic            eval_d;
    logic [ID_W-1:0] rr_d;
    logic [CNT_W-1:0] cnt_d;

    // Operand bit 7 is a, bit 0 is h.
    function automatic logic fn8(input logic [7:0] v);
        return ((v[7] & v[6]) | v[5]) ^ ((v[4] & v[3]) | v[2]) ^ (v[1] & v[0]);
    endfunction

    always_comb begin : search
        int k;
        k     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req_valid[ID_W'(k)]) begin
                found = 1'b1;
                pick  = ID_W'(k);
            end
        end
    end

    assign pick_op = req_operand[{pick, 3'b000} +: 8];
    assign eval_d  = fn8(op_q);
    assign rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) req_ready[pick] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
    end

    assign rsp_result = (state_q == RESP) & eval_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign eval_count = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            op_q    <= '0;
            eval_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        op_q    <= pick_op;
                        grant_q <= pick;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    eval_q  <= eval_d;
                    state_q <= RESP;
                end
                RESP: begin
                    // Only the granted requester's rsp_ready completes the response.
                    if (rsp_ready[grant_q]) begin
                        cnt_q   <= cnt_d;
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
